// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-expansion controller.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2,
        LOAD = 2'd3
    } state_e;

    localparam logic [3:0] NR        = 4'd10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1b;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            acc = b[i] ? (acc ^ aa) : acc;
            aa  = xtime(aa);
        end
        return acc;
    endfunction

    logic [7:0] pow_s;
    logic [7:0] inv_s;

    // Inverse as the product x^2 * x^4 * ... * x^128 = x^254; zero maps to zero.
    always_comb begin
        pow_s = in_byte_i;
        inv_s = 8'h01;
        for (int i = 1; i < 8; i++) begin
            pow_s = gf_mul(pow_s, pow_s);
            inv_s = gf_mul(inv_s, pow_s);
        end
        out_byte_o = inv_s
                   ^ {inv_s[6:0], inv_s[7]}
                   ^ {inv_s[5:0], inv_s[7:6]}
                   ^ {inv_s[4:0], inv_s[7:5]}
                   ^ {inv_s[3:0], inv_s[7:4]}
                   ^ 8'h63;
    end

endmodule

// File: rtl/key_schedule.sv
// Existing word XOR chain of the AES-128 key schedule: next round key from K and the g() result.
module key_schedule (
    input  logic [127:0] K,
    input  logic [31:0]  result,
    output logic [127:0] round_key
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;

    assign w0_s      = K[127:96] ^ result;
    assign w1_s      = K[95:64]  ^ w0_s;
    assign w2_s      = K[63:32]  ^ w1_s;
    assign w3_s      = K[31:0]   ^ w2_s;
    assign round_key = {w0_s, w1_s, w2_s, w3_s};

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// Sequential AES-128 key expansion: time-shared S-box computes SubWord(RotWord(W3)),
// key_schedule builds each round key, round keys 0..10 leave over valid/ready.
module aes_key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         done
);

    localparam logic [2:0] STEP_C = 3'(SBOX_PER_CYCLE);
    localparam logic [2:0] LAST_C = 3'(4 - SBOX_PER_CYCLE);

    state_e       state_q;
    logic [127:0] key_q;
    logic [31:0]  sub_q;
    logic [31:0]  sub_d;
    logic [7:0]   rcon_q;
    logic [3:0]   idx_q;
    logic [2:0]   cnt_q;
    logic         busy_q;
    logic         valid_q;
    logic         done_q;

    logic [31:0]  rot_s;
    logic [31:0]  result_s;
    logic [127:0] ks_key_s;
    logic [7:0]   lane_in_s  [SBOX_PER_CYCLE];
    logic [7:0]   lane_out_s [SBOX_PER_CYCLE];

    assign rot_s    = {key_q[23:0], key_q[31:24]};
    assign result_s = {sub_q[31:24] ^ rcon_q, sub_q[23:0]};

    // Lane l handles byte cnt+l of the rotated word, byte 0 being the most significant.
    always_comb begin
        for (int l = 0; l < SBOX_PER_CYCLE; l++) begin
            logic [1:0] b_s;
            b_s          = cnt_q[1:0] + 2'(l);
            lane_in_s[l] = rot_s[{~b_s, 3'b000} +: 8];
        end
    end

    // Merge this cycle's substituted bytes into the SubWord accumulator.
    always_comb begin
        sub_d = sub_q;
        for (int l = 0; l < SBOX_PER_CYCLE; l++) begin
            logic [1:0] b_s;
            b_s                         = cnt_q[1:0] + 2'(l);
            sub_d[{~b_s, 3'b000} +: 8] = lane_out_s[l];
        end
    end

    for (genvar g = 0; g < SBOX_PER_CYCLE; g++) begin : g_lane
        aes_sbox u_sbox (
            .in_byte_i  (lane_in_s[g]),
            .out_byte_o (lane_out_s[g])
        );
    end

    key_schedule u_key_schedule (
        .K         (key_q),
        .result    (result_s),
        .round_key (ks_key_s)
    );

    // Controller FSM; key_q doubles as the registered round_key output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= 128'h0;
            sub_q   <= 32'h0;
            rcon_q  <= RCON_INIT;
            idx_q   <= 4'd0;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= key_in;
                        rcon_q  <= RCON_INIT;
                        idx_q   <= 4'd0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == NR) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            cnt_q   <= 3'd0;
                            state_q <= SUB;
                        end
                    end
                end
                SUB: begin
                    sub_q <= sub_d;
                    cnt_q <= cnt_q + STEP_C;
                    if (cnt_q == LAST_C) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    key_q   <= ks_key_s;
                    rcon_q  <= xtime(rcon_q);
                    idx_q   <= idx_q + 4'd1;
                    valid_q <= 1'b1;
                    state_q <= EMIT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign rk_valid  = valid_q;
    assign rk_index  = idx_q;
    assign round_key = key_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl with 1, 2 and 4 S-box lanes; reference round keys
// come from a table-driven FIPS-197 model and are checked through a scoreboard queue.
module tb_aes_key_expand_ctrl;

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2      = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start     [3];
    logic [127:0] key_in    [3];
    logic         busy      [3];
    logic         rk_valid  [3];
    logic         rk_ready  [3];
    logic [3:0]   rk_index  [3];
    logic [127:0] round_key [3];
    logic         done      [3];

    int           n_checks = 0;
    int           n_fail   = 0;
    exp_t         sb_q[$];
    logic [127:0] exp_rk [11];
    logic [127:0] got_rk [3][11];

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [7:0] sbox_tab [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_key_expand_ctrl #(.SBOX_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .key_in    (key_in[g]),
            .busy      (busy[g]),
            .rk_valid  (rk_valid[g]),
            .rk_ready  (rk_ready[g]),
            .rk_index  (rk_index[g]),
            .round_key (round_key[g]),
            .done      (done[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Word-oriented FIPS-197 expansion into exp_rk[0..10].
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]}
                    ^ {rcon_tab[i / 4 - 1], 24'h000000};
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic push_expected(input logic [127:0] k);
        build_model(k);
        for (int r = 0; r < 11; r++) sb_q.push_back({4'(r), exp_rk[r]});
    endtask

    // One expansion on DUT d; cycle 0 is the cycle in which start is accepted.
    task automatic run(input int d, input logic [127:0] key, input int rdy_pct, input bit skip_start,
                       input int mid_cyc, input bit chain, input logic [127:0] chain_key,
                       input int abort_cyc, output int done_cyc, output int period);
        int           cyc = 0;
        int           hs0 = -1;
        int           hs1 = -1;
        bit           stall = 1'b0;
        bit           fin = 1'b0;
        logic [127:0] held_key = 128'h0;
        logic [3:0]   held_idx = 4'd0;
        exp_t         e;
        done_cyc = -1;
        period   = -1;
        if (!skip_start) begin
            @(negedge clk);
            start[d]  = 1'b1;
            key_in[d] = key;
        end
        while (!fin) begin
            @(negedge clk);
            cyc++;
            start[d] = 1'b0;
            if (cyc == mid_cyc) begin
                start[d]  = 1'b1;
                key_in[d] = ~key;
            end
            if (cyc == 1) begin
                chk("busy_after_start", 128'(busy[d]), 128'(1'b1));
                chk("rk0_valid_latency", 128'(rk_valid[d]), 128'(1'b1));
                chk("done_single_pulse", 128'(done[d]), 128'(1'b0));
            end
            if (stall) begin
                chk("stall_valid_held", 128'(rk_valid[d]), 128'(1'b1));
                chk("stall_index_held", 128'(rk_index[d]), 128'(held_idx));
                chk("stall_key_held", round_key[d], held_key);
            end
            if (cyc == abort_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("abort_valid", 128'(rk_valid[d]), 128'(1'b0));
                chk("abort_busy", 128'(busy[d]), 128'(1'b0));
                chk("abort_index", 128'(rk_index[d]), 128'(4'd0));
                chk("abort_key", round_key[d], 128'h0);
                chk("abort_done", 128'(done[d]), 128'(1'b0));
                sb_q.delete();
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            rk_ready[d] = ($urandom_range(99) < rdy_pct);
            if (rk_valid[d] && rk_ready[d]) begin
                e = (sb_q.size() > 0) ? sb_q.pop_front() : {4'hf, 128'h0};
                chk("rk_index", 128'(rk_index[d]), 128'(e.idx));
                chk("round_key", round_key[d], e.key);
                got_rk[d][rk_index[d]] = round_key[d];
                if (rk_index[d] == 4'd0) hs0 = cyc;
                if (rk_index[d] == 4'd1) hs1 = cyc;
            end
            stall    = rk_valid[d] && !rk_ready[d];
            held_key = round_key[d];
            held_idx = rk_index[d];
            if (done[d]) begin
                done_cyc = cyc;
                fin      = 1'b1;
                chk("busy_clear_at_done", 128'(busy[d]), 128'(1'b0));
                chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));
                if (chain) begin
                    start[d]  = 1'b1;
                    key_in[d] = chain_key;
                end
            end
            if (cyc > 3000) begin
                chk("timeout_waiting_done", 128'(cyc), 128'(0));
                fin = 1'b1;
            end
        end
        period = hs1 - hs0;
    endtask

    initial begin
        int dc;
        int per;
        int exp_per [3] = '{6, 4, 3};
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            start[d]    = 1'b0;
            key_in[d]   = 128'h0;
            rk_ready[d] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 128'(busy[0]), 128'(1'b0));
        chk("reset_valid", 128'(rk_valid[0]), 128'(1'b0));
        chk("reset_index", 128'(rk_index[0]), 128'(4'd0));
        chk("reset_key", round_key[0], 128'h0);
        chk("reset_done", 128'(done[0]), 128'(1'b0));
        rst_n = 1'b1;

        // FIPS-197 key, always ready
        push_expected(K1);
        run(0, K1, 100, 1'b0, -1, 1'b0, 128'h0, -1, dc, per);
        chk("t1_done_cycle", 128'(dc), 128'(62));
        chk("t1_period", 128'(per), 128'(6));
        chk("t1_rk0", got_rk[0][0], K1);
        chk("t1_rk1", got_rk[0][1], K1_RK1);
        chk("t1_rk10", got_rk[0][10], K1_RK10);

        // Second key
        push_expected(K2);
        run(0, K2, 100, 1'b0, -1, 1'b0, 128'h0, -1, dc, per);
        chk("t2_rk10", got_rk[0][10], K2_RK10);

        // Backpressure
        push_expected(K1);
        run(0, K1, 30, 1'b0, -1, 1'b0, 128'h0, -1, dc, per);
        chk("t3_rk10", got_rk[0][10], K1_RK10);

        // Start while busy, then a new start in the done cycle
        push_expected(K1);
        run(0, K1, 100, 1'b0, 20, 1'b1, K2, -1, dc, per);
        chk("t4_done_cycle", 128'(dc), 128'(62));
        push_expected(K2);
        run(0, K2, 100, 1'b1, -1, 1'b0, 128'h0, -1, dc, per);
        chk("t4_chained_done_cycle", 128'(dc), 128'(62));
        chk("t4_chained_rk10", got_rk[0][10], K2_RK10);

        // Reset during the SUB phase after round 5, then a clean run
        push_expected(K1);
        run(0, K1, 100, 1'b0, -1, 1'b0, 128'h0, 33, dc, per);
        push_expected(K1);
        run(0, K1, 100, 1'b0, -1, 1'b0, 128'h0, -1, dc, per);
        chk("t5_rk10", got_rk[0][10], K1_RK10);

        // Wider S-box lanes
        for (int d = 1; d < 3; d++) begin
            push_expected(K1);
            run(d, K1, 100, 1'b0, -1, 1'b0, 128'h0, -1, dc, per);
            chk("t6_period", 128'(per), 128'(exp_per[d]));
            chk("t6_done_cycle", 128'(dc), 128'(2 + 10 * exp_per[d]));
            chk("t6_rk10", got_rk[d][10], K1_RK10);
            push_expected(K1);
            run(d, K1, 30, 1'b0, -1, 1'b0, 128'h0, -1, dc, per);
            chk("t6_bp_rk10", got_rk[d][10], K1_RK10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
